// File: rtl/usb_rx_if.sv
// USB receive-side bus: raw line inputs, back-pressure, and the byte/packet
// outputs of the receiver core.
//
// Handshake: w_enable is a one-cycle valid strobe qualifying rx_data. rx_full
// acts as an inverted ready sampled when a byte completes. If rx_full is high
// at that moment, the byte is dropped and never retried, and the core flags
// rx_error. No byte is ever held waiting for space.
interface usb_rx_if;
  logic       d_plus_in;
  logic       d_minus_in;
  logic       rx_full;
  logic [7:0] rx_data;
  logic       w_enable;
  logic [3:0] rx_pid;
  logic       receiving;
  logic       rx_error;
  logic       rx_done;

  modport master (
    output d_plus_in, d_minus_in, rx_full,
    input  rx_data, w_enable, rx_pid, receiving, rx_error, rx_done
  );

  modport slave (
    input  d_plus_in, d_minus_in, rx_full,
    output rx_data, w_enable, rx_pid, receiving, rx_error, rx_done
  );
endinterface

// File: rtl/usb_rx_core.sv
// USB full-speed style receiver. The line is oversampled 8x. The core
// performs NRZI decoding and bit-unstuffing, checks SYNC and PID, assembles
// bytes LSB-first and handles EOP. dbg_state exposes the FSM state.
module usb_rx_core (
  input  logic       clk,
  input  logic       n_rst,
  usb_rx_if.slave    bus,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, EOP, ERR} state_t;

  state_t     state_q, state_n;
  logic       dp_meta, dp, dm_meta, dm, dp_d;
  logic [2:0] timer_q;
  logic       prev_dp_q, prev_dp_n;
  logic [2:0] bit_cnt_q, bit_cnt_n;
  logic [2:0] ones_q, ones_n;
  logic [7:0] shift_q, shift_n;
  logic [7:0] rx_data_q, rx_data_n;
  logic [3:0] rx_pid_q, rx_pid_n;
  logic       err_q, err_n;
  logic       wen_q, wen_n;
  logic       done_q, done_n;

  logic       strobe, se0, j_line, rx_bit;
  logic [7:0] byte_next;

  // Two-flop synchronizers plus a delayed copy of dp for edge detection.
  // Reset leaves the line looking like idle J.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      dp_meta <= 1'b1;
      dp      <= 1'b1;
      dm_meta <= 1'b0;
      dm      <= 1'b0;
      dp_d    <= 1'b1;
    end else begin
      dp_meta <= bus.d_plus_in;
      dp      <= dp_meta;
      dm_meta <= bus.d_minus_in;
      dm      <= dm_meta;
      dp_d    <= dp;
    end
  end

  // Bit timer realigns on every dp transition so the strobe lands mid-bit.
  always_ff @(posedge clk) begin
    if (!n_rst)          timer_q <= 3'd0;
    else if (dp != dp_d) timer_q <= 3'd0;
    else                 timer_q <= timer_q + 3'd1;
  end

  assign strobe    = (timer_q == 3'd3);
  assign se0       = !dp && !dm;
  assign j_line    = dp && !dm;
  assign rx_bit    = (dp == prev_dp_q);
  assign byte_next = {rx_bit, shift_q[7:1]};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      prev_dp_q <= 1'b1;
      bit_cnt_q <= 3'd0;
      ones_q    <= 3'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      rx_pid_q  <= 4'h0;
      err_q     <= 1'b0;
      wen_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      prev_dp_q <= prev_dp_n;
      bit_cnt_q <= bit_cnt_n;
      ones_q    <= ones_n;
      shift_q   <= shift_n;
      rx_data_q <= rx_data_n;
      rx_pid_q  <= rx_pid_n;
      err_q     <= err_n;
      wen_q     <= wen_n;
      done_q    <= done_n;
    end
  end

  // Next-state, decode, unstuff and byte assembly.
  always_comb begin
    state_n   = state_q;
    prev_dp_n = prev_dp_q;
    bit_cnt_n = bit_cnt_q;
    ones_n    = ones_q;
    shift_n   = shift_q;
    rx_data_n = rx_data_q;
    rx_pid_n  = rx_pid_q;
    err_n     = err_q;
    wen_n     = 1'b0;
    done_n    = 1'b0;

    if (strobe && state_q != IDLE) prev_dp_n = dp;

    case (state_q)
      IDLE: begin
        // Hold the NRZI reference at J so the first SYNC K decodes as 0.
        prev_dp_n = 1'b1;
        if (dp_d && !dp) begin
          state_n   = SYNC;
          err_n     = 1'b0;
          ones_n    = 3'd0;
          bit_cnt_n = 3'd0;
        end
      end
      SYNC, PID, DATA: begin
        if (strobe) begin
          if (se0) begin
            // Only an SE0 on a byte boundary inside DATA is a clean EOP.
            if (state_q != DATA || bit_cnt_q != 3'd0) err_n = 1'b1;
            state_n = EOP;
          end else if (ones_q == 3'd6) begin
            // Stuff bit: a 0 is dropped, a 1 is a stuffing violation.
            ones_n = 3'd0;
            if (rx_bit) begin
              err_n   = 1'b1;
              state_n = ERR;
            end
          end else begin
            ones_n    = rx_bit ? ones_q + 3'd1 : 3'd0;
            shift_n   = byte_next;
            bit_cnt_n = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == SYNC) begin
                if (byte_next == 8'h80) begin
                  state_n = PID;
                end else begin
                  err_n   = 1'b1;
                  state_n = ERR;
                end
              end else if (state_q == PID) begin
                rx_pid_n = byte_next[3:0];
                if (byte_next[7:4] != ~byte_next[3:0]) begin
                  err_n   = 1'b1;
                  state_n = ERR;
                end else begin
                  state_n = DATA;
                end
              end else begin
                if (bus.rx_full) begin
                  err_n = 1'b1;
                end else begin
                  rx_data_n = byte_next;
                  wen_n     = 1'b1;
                end
              end
            end
          end
        end
      end
      EOP: begin
        if (strobe && j_line) begin
          state_n = IDLE;
          done_n  = !err_q;
        end
      end
      ERR: begin
        if (strobe && se0) state_n = EOP;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_pid    = rx_pid_q;
  assign bus.w_enable  = wen_q;
  assign bus.rx_done   = done_q;
  assign bus.rx_error  = err_q;
  assign bus.receiving = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_usb_rx_core.sv
// Directed bench for usb_rx_core: NRZI/bit-stuffing line driver, scoreboard
// of expected written bytes, pulse counters and a final report.
module tb_usb_rx_core;

  logic       clk;
  logic       n_rst;
  logic [2:0] dbg_state;

  usb_rx_if bus();

  usb_rx_core dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and scoreboard state.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int         checks   = 0;
  int         errors   = 0;
  int         wen_cnt  = 0;
  int         done_cnt = 0;
  logic       wen_prev = 1'b0;
  logic       done_prev = 1'b0;

  // Line encoder state.
  logic line_dp;
  int   ones;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every write strobe, count pulses.
  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.w_enable) begin
        wen_cnt++;
        checks++;
        assert (!wen_prev) else begin
          errors++;
          $error("FAIL wen_width: observed 2+ cycles expected 1");
        end
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL wen_unexpected: observed data %0h expected no write", bus.rx_data);
        end
        if (exp_q.size() != 0) check("rx_data_sb", bus.rx_data, exp_q.pop_front());
      end
      if (bus.rx_done) begin
        done_cnt++;
        checks++;
        assert (!done_prev) else begin
          errors++;
          $error("FAIL done_width: observed 2+ cycles expected 1");
        end
      end
    end
    wen_prev  = bus.w_enable;
    done_prev = bus.rx_done;
  end

  // Driver tasks.
  task automatic drive_line(input logic p, input logic m);
    bus.d_plus_in  = p;
    bus.d_minus_in = m;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic b);
    if (!b) line_dp = ~line_dp;
    drive_line(line_dp, ~line_dp);
  endtask

  task automatic send_bit(input logic b, input logic stuff_val);
    send_raw(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      send_raw(stuff_val);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input logic stuff_val);
    for (int i = 0; i < 8; i++) send_bit(v[i], stuff_val);
  endtask

  task automatic send_sync_pid(input logic [7:0] sync_v, input logic [7:0] pid_v);
    line_dp = 1'b1;
    ones    = 0;
    send_byte(sync_v, 1'b0);
    send_byte(pid_v, 1'b0);
  endtask

  task automatic send_eop();
    drive_line(1'b0, 1'b0);
    drive_line(1'b0, 1'b0);
    drive_line(1'b1, 1'b0);
    line_dp = 1'b1;
    ones    = 0;
    drive_line(1'b1, 1'b0);
    drive_line(1'b1, 1'b0);
  endtask

  int wen0, done0;

  task automatic mark();
    wen0  = wen_cnt;
    done0 = done_cnt;
  endtask

  // Directed sequence.
  initial begin
    n_rst          = 1'b0;
    bus.d_plus_in  = 1'b1;
    bus.d_minus_in = 1'b0;
    bus.rx_full    = 1'b0;
    line_dp        = 1'b1;
    ones           = 0;
    repeat (4) @(posedge clk);
    #1;

    // Reset state.
    @(negedge clk);
    check("rst_rx_data",   bus.rx_data,   8'h00);
    check("rst_rx_pid",    bus.rx_pid,    4'h0);
    check("rst_w_enable",  bus.w_enable,  1'b0);
    check("rst_receiving", bus.receiving, 1'b0);
    check("rst_rx_error",  bus.rx_error,  1'b0);
    check("rst_rx_done",   bus.rx_done,   1'b0);
    check("rst_state",     dbg_state,     3'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    drive_line(1'b1, 1'b0);
    drive_line(1'b1, 1'b0);

    // Clean DATA0 packet with two bytes.
    mark();
    send_sync_pid(8'h80, 8'hC3);
    check("p1_receiving", bus.receiving, 1'b1);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b0);
    send_eop();
    check("p1_wen_count",  wen_cnt - wen0,   2);
    check("p1_done_count", done_cnt - done0, 1);
    check("p1_rx_pid",     bus.rx_pid,   4'h3);
    check("p1_rx_data",    bus.rx_data,  8'h3C);
    check("p1_rx_error",   bus.rx_error, 1'b0);
    check("p1_receiving",  bus.receiving, 1'b0);

    // 0xFF with a proper stuffed zero.
    mark();
    send_sync_pid(8'h80, 8'hC3);
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b0);
    send_eop();
    check("stuff_ok_data",  bus.rx_data, 8'hFF);
    check("stuff_ok_err",   bus.rx_error, 1'b0);
    check("stuff_ok_done",  done_cnt - done0, 1);

    // Same stream, stuffed bit is a 1.
    mark();
    send_sync_pid(8'h80, 8'hC3);
    send_byte(8'hFF, 1'b1);
    check("stuff_bad_state", dbg_state, 3'd5);
    send_eop();
    check("stuff_bad_err",  bus.rx_error, 1'b1);
    check("stuff_bad_wen",  wen_cnt - wen0, 0);
    check("stuff_bad_done", done_cnt - done0, 0);

    // Corrupt SYNC.
    mark();
    send_sync_pid(8'h81, 8'hC3);
    check("sync_bad_err",   bus.rx_error, 1'b1);
    check("sync_bad_state", dbg_state, 3'd5);
    send_eop();
    check("sync_bad_wen",   wen_cnt - wen0, 0);
    check("sync_bad_done",  done_cnt - done0, 0);
    check("sync_bad_recv",  bus.receiving, 1'b0);

    // PID check-nibble mismatch.
    mark();
    send_sync_pid(8'h80, 8'hC4);
    check("pid_bad_err",  bus.rx_error, 1'b1);
    send_eop();
    check("pid_bad_done", done_cnt - done0, 0);

    // SE0 three bits into a data byte.
    mark();
    send_sync_pid(8'h80, 8'hC3);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_eop();
    check("short_err",  bus.rx_error, 1'b1);
    check("short_wen",  wen_cnt - wen0, 0);
    check("short_done", done_cnt - done0, 0);

    // Byte dropped while the buffer is full, next byte accepted.
    mark();
    send_sync_pid(8'h80, 8'hC3);
    bus.rx_full = 1'b1;
    send_byte(8'h55, 1'b0);
    bus.rx_full = 1'b0;
    check("full_err",   bus.rx_error, 1'b1);
    check("full_wen",   wen_cnt - wen0, 0);
    check("full_state", dbg_state, 3'd3);
    exp_q.push_back(8'h96);
    send_byte(8'h96, 1'b0);
    send_eop();
    check("full_next_data", bus.rx_data, 8'h96);
    check("full_next_wen",  wen_cnt - wen0, 1);
    check("full_done",      done_cnt - done0, 0);

    // Reset pulse in the middle of DATA.
    mark();
    send_sync_pid(8'h80, 8'hC3);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    bus.d_plus_in  = 1'b1;
    bus.d_minus_in = 1'b0;
    line_dp        = 1'b1;
    n_rst          = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    check("mid_rst_rx_data",   bus.rx_data,   8'h00);
    check("mid_rst_rx_pid",    bus.rx_pid,    4'h0);
    check("mid_rst_w_enable",  bus.w_enable,  1'b0);
    check("mid_rst_receiving", bus.receiving, 1'b0);
    check("mid_rst_rx_error",  bus.rx_error,  1'b0);
    check("mid_rst_rx_done",   bus.rx_done,   1'b0);
    drive_line(1'b1, 1'b0);
    drive_line(1'b1, 1'b0);
    send_sync_pid(8'h80, 8'hC3);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b0);
    send_eop();
    check("post_rst_wen",  wen_cnt - wen0, 1);
    check("post_rst_done", done_cnt - done0, 1);
    check("post_rst_err",  bus.rx_error, 1'b0);
    check("post_rst_data", bus.rx_data, 8'h5A);

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
